// File: rtl/voice_allocator.sv
// Purpose : polyphonic voice allocator; maps MIDI note events onto VOICES slots feeding per-voice Envelopes.
// Latency : one cycle, event sampled on an edge -> pulses and note/velocity registers visible after that edge.
// Backpres: none, every event is accepted unconditionally; a full pool is resolved by stealing.
// Ports   : clock_50_000_000/reset_l; event_* note events; sustain_pedal level; envelope_end per voice;
//           voice_note_on/off pulses, packed voice_note/voice_velocity, voice_active per voice.
module voice_allocator #(
    parameter int VOICES = 8,
    parameter int NOTE_W = 7,
    parameter int VEL_W  = 7
) (
    input  logic                     clock_50_000_000,
    input  logic                     reset_l,
    input  logic                     event_valid,
    input  logic                     event_is_on,
    input  logic [NOTE_W-1:0]        event_note,
    input  logic [VEL_W-1:0]         event_velocity,
    input  logic                     sustain_pedal,
    input  logic [VOICES-1:0]        envelope_end,
    output logic [VOICES-1:0]        voice_note_on,
    output logic [VOICES-1:0]        voice_note_off,
    output logic [VOICES*NOTE_W-1:0] voice_note,
    output logic [VOICES*VEL_W-1:0]  voice_velocity,
    output logic [VOICES-1:0]        voice_active
);
    localparam int PTR_W = (VOICES > 1) ? $clog2(VOICES) : 1;

    typedef enum logic [1:0] {FREE, HELD, SUSTAINED, RELEASING} slot_state_t;

    slot_state_t              state      [VOICES];
    slot_state_t              state_next [VOICES];
    logic [PTR_W-1:0]         steal_ptr, steal_ptr_next;
    logic                     pedal_prev;
    logic [VOICES-1:0]        on_next, off_next, active_next;
    logic [VOICES*NOTE_W-1:0] note_next;
    logic [VOICES*VEL_W-1:0]  vel_next;

    logic             is_on, is_off, pedal_fall;
    logic             retrig_hit, free_hit, rel_hit, off_hit;
    logic [PTR_W-1:0] retrig_idx, free_idx, rel_idx, off_idx, target;

    // A note-on with velocity 0 is a note-off.
    assign is_on      = event_valid && event_is_on && (event_velocity != '0);
    assign is_off     = event_valid && !is_on;
    assign pedal_fall = pedal_prev && !sustain_pedal;

    always_comb begin
        on_next        = '0;
        off_next       = '0;
        note_next      = voice_note;
        vel_next       = voice_velocity;
        steal_ptr_next = steal_ptr;
        retrig_hit     = 1'b0;
        free_hit       = 1'b0;
        rel_hit        = 1'b0;
        off_hit        = 1'b0;
        retrig_idx     = '0;
        free_idx       = '0;
        rel_idx        = '0;
        off_idx        = '0;
        target         = '0;

        // Envelope completion first, so a freed slot is allocatable this cycle.
        for (int i = 0; i < VOICES; i++) begin
            state_next[i] = state[i];
            if (state[i] == RELEASING && envelope_end[i])
                state_next[i] = FREE;
        end

        // Pedal up releases every sustained voice at once.
        if (pedal_fall) begin
            for (int i = 0; i < VOICES; i++) begin
                if (state[i] == SUSTAINED) begin
                    off_next[i]   = 1'b1;
                    state_next[i] = RELEASING;
                end
            end
        end

        // Candidate search, lowest index first. Retrigger matches against the
        // pre-envelope state so a retriggered slot wins over its envelope_end.
        for (int i = 0; i < VOICES; i++) begin
            if (!retrig_hit && state[i] != FREE &&
                voice_note[i*NOTE_W +: NOTE_W] == event_note) begin
                retrig_hit = 1'b1;
                retrig_idx = PTR_W'(i);
            end
            if (!free_hit && state_next[i] == FREE) begin
                free_hit = 1'b1;
                free_idx = PTR_W'(i);
            end
            if (!rel_hit && state_next[i] == RELEASING) begin
                rel_hit = 1'b1;
                rel_idx = PTR_W'(i);
            end
            if (!off_hit && state[i] == HELD &&
                voice_note[i*NOTE_W +: NOTE_W] == event_note) begin
                off_hit = 1'b1;
                off_idx = PTR_W'(i);
            end
        end

        if (is_on) begin
            if (retrig_hit)
                target = retrig_idx;
            else if (free_hit)
                target = free_idx;
            else if (rel_hit)
                target = rel_idx;
            else begin
                target         = steal_ptr;
                steal_ptr_next = (steal_ptr == PTR_W'(VOICES-1)) ? '0 : steal_ptr + 1'b1;
            end
            on_next[target]                     = 1'b1;
            state_next[target]                  = HELD;
            note_next[target*NOTE_W +: NOTE_W]  = event_note;
            vel_next[target*VEL_W +: VEL_W]     = event_velocity;
        end else if (is_off && off_hit) begin
            if (sustain_pedal)
                state_next[off_idx] = SUSTAINED;
            else begin
                off_next[off_idx]   = 1'b1;
                state_next[off_idx] = RELEASING;
            end
        end

        for (int i = 0; i < VOICES; i++)
            active_next[i] = (state_next[i] != FREE);
    end

    always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
        if (!reset_l) begin
            for (int i = 0; i < VOICES; i++)
                state[i] <= FREE;
            steal_ptr      <= '0;
            pedal_prev     <= 1'b0;
            voice_note_on  <= '0;
            voice_note_off <= '0;
            voice_note     <= '0;
            voice_velocity <= '0;
            voice_active   <= '0;
        end else begin
            for (int i = 0; i < VOICES; i++)
                state[i] <= state_next[i];
            steal_ptr      <= steal_ptr_next;
            pedal_prev     <= sustain_pedal;
            voice_note_on  <= on_next;
            voice_note_off <= off_next;
            voice_note     <= note_next;
            voice_velocity <= vel_next;
            voice_active   <= active_next;
        end
    end
endmodule
